// File: rtl/real_param_ramp_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel fixed-point ramp.
package real_param_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Truncates toward zero, then wraps into the WIDTH-bit unsigned range.
    function automatic logic [63:0] quantise_step(
        input real base,
        input real delta,
        input int  ch,
        input int  frac,
        input int  width
    );
        real         r;
        logic [63:0] q;
        logic [63:0] mask;
        r    = (base + ch * delta) * (2.0 ** frac);
        q    = 64'($rtoi(r));
        mask = (64'd1 << width) - 64'd1;
        return q & mask;
    endfunction

endpackage

// File: rtl/real_param_ramp_if.sv
// Start handshake and result bus of the ramp generator; master drives start, slave reports status.
interface real_param_ramp_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
);
    logic                   start_i;
    logic                   ready_o;
    logic                   busy_o;
    logic                   done_o;
    logic [NCH*WIDTH-1:0]   value_o;
    logic [NCH-1:0]         ovf_o;
    logic [NCH*WIDTH-1:0]   step_q_o;

    modport master (
        output start_i,
        input  ready_o, busy_o, done_o, value_o, ovf_o, step_q_o
    );

    modport slave (
        input  start_i,
        output ready_o, busy_o, done_o, value_o, ovf_o, step_q_o
    );
endinterface

// File: rtl/real_param_ramp_ch.sv
// One ramp channel: wrapping accumulator with sticky carry-out flag and a fixed quantised step.
// Updates one cycle after clr_i/adv_i; no backpressure, the shared FSM paces it.
module real_param_ramp_ch
    import real_param_ramp_pkg::*;
#(
    parameter real STEP  = 0.5,
    parameter int  WIDTH = 16,
    parameter int  FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] step_q_o
);

    localparam logic [WIDTH-1:0] STEP_Q = WIDTH'(quantise_step(STEP, 0.0, 0, FRAC, WIDTH));

    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [WIDTH:0]   sum_d;

    // Extra MSB captures the unsigned carry that marks a wrap.
    assign sum_d = {1'b0, acc_q} + {1'b0, STEP_Q};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv_i) begin
            acc_q <= sum_d[WIDTH-1:0];
            if (sum_d[WIDTH]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign acc_o    = acc_q;
    assign ovf_o    = ovf_q;
    assign step_q_o = STEP_Q;

endmodule

// File: rtl/real_param_ramp.sv
// Multi-channel ramp: on an accepted start every channel adds its step LEN times, then pulses done.
// Start accepted only in IDLE; run period is LEN+2 cycles when start is held high.
module real_param_ramp
    import real_param_ramp_pkg::*;
#(
    parameter int  NCH   = 4,
    parameter int  WIDTH = 16,
    parameter int  FRAC  = 8,
    parameter real BASE  = 0.5,
    parameter real DELTA = 1.25,
    parameter int  LEN   = 8
) (
    input logic              clk,
    input logic              rst,
    real_param_ramp_if.slave bus
);

    localparam int CW = $clog2(LEN + 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 clr;
    logic                 adv;
    logic [NCH*WIDTH-1:0] value;
    logic [NCH*WIDTH-1:0] step_q;
    logic [NCH-1:0]       ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                adv   = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        localparam real CH_STEP = BASE + ch * DELTA;

        real_param_ramp_ch #(
            .STEP  (CH_STEP),
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (clr),
            .adv_i    (adv),
            .acc_o    (value[ch*WIDTH +: WIDTH]),
            .ovf_o    (ovf[ch]),
            .step_q_o (step_q[ch*WIDTH +: WIDTH])
        );
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.busy_o   = (state_q == RUN);
    assign bus.done_o   = (state_q == DONE);
    assign bus.value_o  = value;
    assign bus.ovf_o    = ovf;
    assign bus.step_q_o = step_q;

endmodule

// File: tb/tb_real_param_ramp.sv
// Directed bench for real_param_ramp: default, WIDTH=12 and single-channel LEN=1 instances.
module tb_real_param_ramp;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    real_param_ramp_if #(.NCH(4), .WIDTH(16)) ifa ();
    real_param_ramp_if #(.NCH(4), .WIDTH(12)) ifb ();
    real_param_ramp_if #(.NCH(1), .WIDTH(16)) ifc ();

    real_param_ramp #(.NCH(4), .WIDTH(16), .FRAC(8), .BASE(0.5), .DELTA(1.25), .LEN(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    real_param_ramp #(.NCH(4), .WIDTH(12), .FRAC(8), .BASE(0.5), .DELTA(1.25), .LEN(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    real_param_ramp #(.NCH(1), .WIDTH(16), .FRAC(4), .BASE(0.3), .DELTA(1.25), .LEN(1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    localparam logic [63:0] STEP_A  = {16'd1088, 16'd768, 16'd448, 16'd128};
    localparam logic [47:0] STEP_B  = {12'd1088, 12'd768, 12'd448, 12'd128};
    localparam logic [63:0] HALF_A  = {16'd4352, 16'd3072, 16'd1792, 16'd512};
    localparam logic [63:0] FINAL_A = {16'd8704, 16'd6144, 16'd3584, 16'd1024};
    localparam logic [47:0] FINAL_B = {12'd512, 12'd2048, 12'd3584, 12'd1024};

    task automatic test_reset();
        rst = 1'b1;
        ifa.start_i = 1'b1;
        ifb.start_i = 1'b0;
        ifc.start_i = 1'b0;
        repeat (2) @(negedge clk);
        ifa.start_i = 1'b0;
        tests++; if (ifa.step_q_o !== STEP_A) begin fails++; $display("FAIL reset_step_a got=%h exp=%h", ifa.step_q_o, STEP_A); end
        tests++; if (ifb.step_q_o !== STEP_B) begin fails++; $display("FAIL reset_step_b got=%h exp=%h", ifb.step_q_o, STEP_B); end
        tests++; if (ifc.step_q_o !== 16'd4) begin fails++; $display("FAIL reset_step_c got=%0d exp=4", ifc.step_q_o); end
        tests++; if (ifa.value_o !== 64'd0) begin fails++; $display("FAIL reset_value got=%h exp=0", ifa.value_o); end
        tests++; if ({ifa.ready_o, ifa.busy_o, ifa.done_o} !== 3'b100) begin fails++; $display("FAIL reset_status rdy/busy/done got=%b exp=100", {ifa.ready_o, ifa.busy_o, ifa.done_o}); end
        tests++; if (ifa.ovf_o !== 4'b0000) begin fails++; $display("FAIL reset_ovf got=%b exp=0000", ifa.ovf_o); end
        rst = 1'b0;
    endtask

    task automatic test_single_run();
        @(negedge clk); ifa.start_i = 1'b1;
        @(negedge clk); ifa.start_i = 1'b0;
        tests++; if ({ifa.ready_o, ifa.busy_o, ifa.done_o} !== 3'b010) begin fails++; $display("FAIL run_accept status got=%b exp=010", {ifa.ready_o, ifa.busy_o, ifa.done_o}); end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                tests++; if (ifa.value_o !== HALF_A) begin fails++; $display("FAIL run_mid_value got=%h exp=%h", ifa.value_o, HALF_A); end
            end
            if (i < 8) begin
                tests++; if ({ifa.busy_o, ifa.done_o} !== 2'b10) begin fails++; $display("FAIL run_busy i=%0d busy/done got=%b exp=10", i, {ifa.busy_o, ifa.done_o}); end
            end else begin
                tests++; if ({ifa.ready_o, ifa.busy_o, ifa.done_o} !== 3'b001) begin fails++; $display("FAIL run_done status got=%b exp=001", {ifa.ready_o, ifa.busy_o, ifa.done_o}); end
                tests++; if (ifa.value_o !== FINAL_A) begin fails++; $display("FAIL run_final_value got=%h exp=%h", ifa.value_o, FINAL_A); end
                tests++; if (ifa.ovf_o !== 4'b0000) begin fails++; $display("FAIL run_ovf got=%b exp=0000", ifa.ovf_o); end
            end
        end
        @(negedge clk);
        tests++; if ({ifa.ready_o, ifa.busy_o, ifa.done_o} !== 3'b100) begin fails++; $display("FAIL run_idle status got=%b exp=100", {ifa.ready_o, ifa.busy_o, ifa.done_o}); end
        repeat (3) @(negedge clk);
        tests++; if (ifa.value_o !== FINAL_A) begin fails++; $display("FAIL run_hold_value got=%h exp=%h", ifa.value_o, FINAL_A); end
    endtask

    task automatic test_width12();
        @(negedge clk); ifb.start_i = 1'b1;
        @(negedge clk); ifb.start_i = 1'b0;
        repeat (8) @(negedge clk);
        tests++; if (ifb.done_o !== 1'b1) begin fails++; $display("FAIL w12_done got=%b exp=1", ifb.done_o); end
        tests++; if (ifb.value_o !== FINAL_B) begin fails++; $display("FAIL w12_value got=%h exp=%h", ifb.value_o, FINAL_B); end
        tests++; if (ifb.ovf_o !== 4'b1100) begin fails++; $display("FAIL w12_ovf got=%b exp=1100", ifb.ovf_o); end
        @(negedge clk); ifb.start_i = 1'b1;
        @(negedge clk); ifb.start_i = 1'b0;
        tests++; if (ifb.ovf_o !== 4'b0000) begin fails++; $display("FAIL w12_ovf_clear got=%b exp=0000", ifb.ovf_o); end
        tests++; if (ifb.value_o !== 48'd0) begin fails++; $display("FAIL w12_value_clear got=%h exp=0", ifb.value_o); end
        repeat (9) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        @(negedge clk); ifa.start_i = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (ifa.done_o === 1'b1) begin
                dones++;
                tests++; if ((t % 10) != 8) begin fails++; $display("FAIL b2b_done_time t=%0d exp t%%10=8", t); end
                tests++; if (ifa.value_o !== FINAL_A) begin fails++; $display("FAIL b2b_value t=%0d got=%h exp=%h", t, ifa.value_o, FINAL_A); end
            end
            if ((t % 10) == 1) begin
                tests++; if (ifa.value_o[15:0] !== 16'd128) begin fails++; $display("FAIL b2b_restart t=%0d got=%0d exp=128", t, ifa.value_o[15:0]); end
            end
            if ((t % 10) == 9) begin
                tests++; if (ifa.ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready t=%0d got=%b exp=1", t, ifa.ready_o); end
            end
        end
        ifa.start_i = 1'b0;
        tests++; if (dones != 3) begin fails++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int stray = 0;
        @(negedge clk); ifa.start_i = 1'b1;
        @(negedge clk); ifa.start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tests++; if ({ifa.ready_o, ifa.busy_o, ifa.done_o} !== 3'b100) begin fails++; $display("FAIL midrst_status got=%b exp=100", {ifa.ready_o, ifa.busy_o, ifa.done_o}); end
        tests++; if (ifa.value_o !== 64'd0) begin fails++; $display("FAIL midrst_value got=%h exp=0", ifa.value_o); end
        tests++; if (ifa.ovf_o !== 4'b0000) begin fails++; $display("FAIL midrst_ovf got=%b exp=0000", ifa.ovf_o); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifa.done_o !== 1'b0) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL midrst_no_done got=%0d pulses exp=0", stray); end
        ifa.start_i = 1'b1;
        @(negedge clk); ifa.start_i = 1'b0;
        repeat (8) @(negedge clk);
        tests++; if ({ifa.done_o, ifa.value_o} !== {1'b1, FINAL_A}) begin fails++; $display("FAIL midrst_rerun got done=%b val=%h exp done=1 val=%h", ifa.done_o, ifa.value_o, FINAL_A); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_channel();
        @(negedge clk); ifc.start_i = 1'b1;
        @(negedge clk); ifc.start_i = 1'b0;
        tests++; if ({ifc.busy_o, ifc.value_o} !== {1'b1, 16'd0}) begin fails++; $display("FAIL ch1_run got busy=%b val=%0d exp busy=1 val=0", ifc.busy_o, ifc.value_o); end
        @(negedge clk);
        tests++; if ({ifc.done_o, ifc.value_o} !== {1'b1, 16'd4}) begin fails++; $display("FAIL ch1_done got done=%b val=%0d exp done=1 val=4", ifc.done_o, ifc.value_o); end
        @(negedge clk);
        tests++; if ({ifc.ready_o, ifc.value_o} !== {1'b1, 16'd4}) begin fails++; $display("FAIL ch1_idle got rdy=%b val=%0d exp rdy=1 val=4", ifc.ready_o, ifc.value_o); end
    endtask

    initial begin
        rst = 1'b1;
        ifa.start_i = 1'b0;
        ifb.start_i = 1'b0;
        ifc.start_i = 1'b0;
        test_reset();
        test_single_run();
        test_width12();
        test_back_to_back();
        test_reset_mid_run();
        test_single_channel();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
